// File: rtl/mc_proc_controller.sv
// rtl/mc_proc_controller.sv - multi-cycle processor control FSM with bounded data-memory wait
module mc_proc_controller #(
  parameter int DBIT_SIZE   = 32,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DBIT_SIZE-1:0] iword,
  input  logic                 iwordValid,
  input  logic                 aluCompTrue,
  input  logic                 dMemReady,
  output logic [4:0]           aluFn,
  output logic [3:0]           rdIndex0,
  output logic [3:0]           rdIndex1,
  output logic [3:0]           wrtIndex,
  output logic [15:0]          imm,
  output logic                 irWrtEn,
  output logic                 pcWrtEn,
  output logic                 PCSel,
  output logic                 aluSrc2Sel,
  output logic                 regFileWrtSel,
  output logic                 isJAL,
  output logic                 regFileWrtEn,
  output logic                 dMemReq,
  output logic                 dMemWrtEn,
  output logic [2:0]           state,
  output logic                 illegal,
  output logic                 memTimeout
);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_HALT   = 3'd7;

  localparam logic [3:0] OP_ALUR = 4'b0000;
  localparam logic [3:0] OP_ALUI = 4'b1000;
  localparam logic [3:0] OP_LW   = 4'b1001;
  localparam logic [3:0] OP_SW   = 4'b0101;
  localparam logic [3:0] OP_BR   = 4'b0010;
  localparam logic [3:0] OP_JAL  = 4'b1011;

  localparam int CW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [CW-1:0] TIMEOUT_VAL = CW'(MEM_TIMEOUT);

  logic [2:0]    state_q, state_d;
  logic [31:0]   ir_q, ir_d;
  logic [3:0]    op_q, op_d;
  logic [4:0]    alu_fn_q, alu_fn_d;
  logic [3:0]    rd_idx0_q, rd_idx0_d;
  logic [3:0]    rd_idx1_q, rd_idx1_d;
  logic [3:0]    wrt_idx_q, wrt_idx_d;
  logic [15:0]   imm_q, imm_d;
  logic          src2_sel_q, src2_sel_d;
  logic          wrt_sel_q, wrt_sel_d;
  logic          is_jal_q, is_jal_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          illegal_q, illegal_d;
  logic          mem_to_q, mem_to_d;

  logic [3:0]    f_op, f_fn, f_rd, f_rs1, f_rs2;
  logic          f_legal;
  logic [CW-1:0] cnt_inc;
  logic          exec_jump;

  // The instruction is captured at FETCH acceptance so DECODE does not depend on iword still being driven.
  assign f_op    = ir_q[31:28];
  assign f_fn    = ir_q[27:24];
  assign f_rd    = ir_q[23:20];
  assign f_rs1   = ir_q[19:16];
  assign f_rs2   = ir_q[15:12];
  assign f_legal = (f_op == OP_ALUR) || (f_op == OP_ALUI) || (f_op == OP_LW) ||
                   (f_op == OP_SW)   || (f_op == OP_BR)   || (f_op == OP_JAL);
  assign cnt_inc = cnt_q + CW'(1);

  always_comb begin
    state_d    = state_q;
    ir_d       = ir_q;
    op_d       = op_q;
    alu_fn_d   = alu_fn_q;
    rd_idx0_d  = rd_idx0_q;
    rd_idx1_d  = rd_idx1_q;
    wrt_idx_d  = wrt_idx_q;
    imm_d      = imm_q;
    src2_sel_d = src2_sel_q;
    wrt_sel_d  = wrt_sel_q;
    is_jal_d   = is_jal_q;
    cnt_d      = cnt_q;
    illegal_d  = illegal_q;
    mem_to_d   = mem_to_q;
    case (state_q)
      S_FETCH: begin
        if (iwordValid) begin
          ir_d    = iword[31:0];
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        if (!f_legal) begin
          state_d   = S_HALT;
          illegal_d = 1'b1;
        end else begin
          op_d       = f_op;
          rd_idx0_d  = f_rs1;
          rd_idx1_d  = ((f_op == OP_SW) || (f_op == OP_BR)) ? f_rd : f_rs2;
          wrt_idx_d  = f_rd;
          imm_d      = ir_q[15:0];
          src2_sel_d = (f_op == OP_ALUI) || (f_op == OP_LW) || (f_op == OP_SW) || (f_op == OP_JAL);
          wrt_sel_d  = (f_op == OP_LW);
          is_jal_d   = (f_op == OP_JAL);
          if ((f_op == OP_ALUR) || (f_op == OP_ALUI)) begin
            alu_fn_d = {1'b0, f_fn};
          end else if (f_op == OP_BR) begin
            alu_fn_d = {1'b1, f_fn};
          end else begin
            alu_fn_d = 5'b00000;
          end
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if ((op_q == OP_LW) || (op_q == OP_SW)) begin
          state_d = S_MEM;
          cnt_d   = '0;
        end else if (op_q == OP_BR) begin
          state_d = S_FETCH;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        // Ready wins over the timeout when both land on the same cycle.
        if (dMemReady) begin
          state_d = (op_q == OP_LW) ? S_WB : S_FETCH;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == TIMEOUT_VAL) begin
            state_d  = S_HALT;
            mem_to_d = 1'b1;
          end
        end
      end
      S_WB:    state_d = S_FETCH;
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_FETCH;
      ir_q       <= '0;
      op_q       <= '0;
      alu_fn_q   <= '0;
      rd_idx0_q  <= '0;
      rd_idx1_q  <= '0;
      wrt_idx_q  <= '0;
      imm_q      <= '0;
      src2_sel_q <= 1'b0;
      wrt_sel_q  <= 1'b0;
      is_jal_q   <= 1'b0;
      cnt_q      <= '0;
      illegal_q  <= 1'b0;
      mem_to_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      ir_q       <= ir_d;
      op_q       <= op_d;
      alu_fn_q   <= alu_fn_d;
      rd_idx0_q  <= rd_idx0_d;
      rd_idx1_q  <= rd_idx1_d;
      wrt_idx_q  <= wrt_idx_d;
      imm_q      <= imm_d;
      src2_sel_q <= src2_sel_d;
      wrt_sel_q  <= wrt_sel_d;
      is_jal_q   <= is_jal_d;
      cnt_q      <= cnt_d;
      illegal_q  <= illegal_d;
      mem_to_q   <= mem_to_d;
    end
  end

  // Strobes come from the registered state and op, qualified only by the input owned by that state.
  assign exec_jump    = (state_q == S_EXEC) &&
                        ((op_q == OP_JAL) || ((op_q == OP_BR) && aluCompTrue));
  assign irWrtEn      = (state_q == S_FETCH) && iwordValid;
  assign pcWrtEn      = irWrtEn || exec_jump;
  assign PCSel        = exec_jump;
  assign regFileWrtEn = (state_q == S_WB);
  assign dMemReq      = (state_q == S_MEM);
  assign dMemWrtEn    = (state_q == S_MEM) && (op_q == OP_SW);

  assign aluFn         = alu_fn_q;
  assign rdIndex0      = rd_idx0_q;
  assign rdIndex1      = rd_idx1_q;
  assign wrtIndex      = wrt_idx_q;
  assign imm           = imm_q;
  assign aluSrc2Sel    = src2_sel_q;
  assign regFileWrtSel = wrt_sel_q;
  assign isJAL         = is_jal_q;
  assign state         = state_q;
  assign illegal       = illegal_q;
  assign memTimeout    = mem_to_q;

endmodule

// File: doc/mc_proc_controller.md
MC_PROC_CONTROLLER -- requirements
Module: mc_proc_controller

Interface
REQ-001 Parameter DBIT_SIZE, default 32: instruction word width; SHALL be at least 32; fields occupy iword[31:0], and upper bits are ignored.
REQ-002 Parameter MEM_TIMEOUT, default 15: maximum number of MEM-state cycles waiting for dMemReady before error.
REQ-003 Port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 Port reset, input, 1: synchronous, active-high reset.
REQ-005 Port iword, input, DBIT_SIZE: instruction from instruction memory.
REQ-006 Port iwordValid, input, 1: iword is valid this cycle.
REQ-007 Port aluCompTrue, input, 1: ALU comparison result, sampled in EXEC.
REQ-008 Port dMemReady, input, 1: data-memory access completes this cycle.
REQ-009 Port aluFn, output, 5: ALU function select.
REQ-010 Ports rdIndex0, rdIndex1 and wrtIndex, output, 4 each: register-file read and write indices.
REQ-011 Port imm, output, 16: raw immediate.
REQ-012 Ports irWrtEn, pcWrtEn, PCSel, aluSrc2Sel, regFileWrtSel, isJAL, regFileWrtEn, dMemReq, dMemWrtEn, output, 1 each: datapath strobes and selects.
REQ-013 Port state, output, 3: current FSM state, for debug.
REQ-014 Ports illegal and memTimeout, output, 1 each: sticky error flags.

Function
REQ-015 State encoding SHALL be FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=7.
REQ-016 Instruction fields SHALL be: op=iword[31:28], fn=iword[27:24], rd=iword[23:20], rs1=iword[19:16], rs2=iword[15:12], imm=iword[15:0].
REQ-017 Opcodes SHALL be: ALUR=0000, ALUI=1000, LW=1001, SW=0101, BR=0010, JAL=1011; every other op is illegal.
REQ-018 FETCH SHALL wait for iwordValid, then assert irWrtEn and pcWrtEn (PCSel=0) for one cycle and go to DECODE.
REQ-019 In DECODE, the controller SHALL latch aluFn, rdIndex0, rdIndex1, wrtIndex, imm, aluSrc2Sel, regFileWrtSel and isJAL; these outputs hold until the next DECODE.
REQ-020 On an illegal op, DECODE SHALL go to HALT, set illegal, and not modify the latched field outputs.
REQ-021 aluFn SHALL be {0,fn} for ALUR/ALUI, {1,fn} for BR, and 00000 for LW, SW and JAL.
REQ-022 rdIndex0 SHALL be rs1 for all ops; rdIndex1 SHALL be rs2 for ALUR, and rd for SW and BR.
REQ-023 wrtIndex SHALL be rd; aluSrc2Sel SHALL be 1 for ALUI, LW, SW and JAL; regFileWrtSel SHALL be 1 for LW; isJAL SHALL be 1 for JAL only.
REQ-024 EXEC SHALL transition as follows: ALUR/ALUI/JAL to WB; LW/SW to MEM; BR to FETCH.
REQ-025 In EXEC, a BR with aluCompTrue=1, and any JAL, SHALL assert pcWrtEn=1 and PCSel=1 for that cycle; a BR with aluCompTrue=0 asserts neither.
REQ-026 MEM SHALL assert dMemReq every cycle, and dMemWrtEn every cycle for SW, until dMemReady; then LW goes to WB and SW goes to FETCH.
REQ-027 The MEM wait counter SHALL clear on MEM entry and increment each MEM cycle without dMemReady.
REQ-028 When the counter reaches MEM_TIMEOUT, the FSM SHALL go to HALT and set memTimeout.
REQ-029 dMemReady in the same cycle the counter reaches MEM_TIMEOUT SHALL count as success.
REQ-030 WB SHALL assert regFileWrtEn for one cycle, then go to FETCH.
REQ-031 Cycle counts from FETCH acceptance, with zero memory wait, SHALL be: ALUR/ALUI/JAL 4, BR 3, SW 4, LW 5.
REQ-032 HALT SHALL be absorbing: all strobes stay 0 and the error flags stay set until reset.
REQ-033 All strobes (irWrtEn, pcWrtEn, PCSel, regFileWrtEn, dMemReq, dMemWrtEn) SHALL be Moore-decoded from the state and the latched op; they SHALL never be asserted outside their own state.
REQ-034 iwordValid and dMemReady SHALL be ignored in every state except FETCH and MEM respectively.

Reset
REQ-035 When reset=1 at a clock edge, the next state SHALL be FETCH and all outputs, latched fields, the counter and the error flags SHALL be 0; reset SHALL override every other input, including mid-MEM and in HALT.
REQ-036 A memory access interrupted by reset SHALL be abandoned: dMemReq and dMemWrtEn are 0 in the cycle after the reset edge.

Verification
REQ-037 ADD s0,s1,s2: iword=0x0xxx with rd=3, rs1=4, rs2=5, iwordValid=1 -> states 0,1,2,4,0; aluFn=00000, rdIndex0=4, rdIndex1=5, wrtIndex=3; regFileWrtEn=1 only in WB.
REQ-038 BR with fn=0001, aluCompTrue=1 -> aluFn=10001; pcWrtEn=1 and PCSel=1 in EXEC, then FETCH. Repeating with aluCompTrue=0 -> no pcWrtEn in EXEC.
REQ-039 LW with dMemReady held low for 3 cycles -> MEM lasts 4 cycles with dMemReq=1 and dMemWrtEn=0; then WB with regFileWrtSel=1.
REQ-040 SW with dMemReady never asserted, MEM_TIMEOUT=15 -> HALT after 15 MEM cycles; memTimeout=1 and state=7 persist until reset.
REQ-041 op=1111 -> HALT after DECODE, illegal=1; then reset=1 for one cycle -> state=0 and all outputs 0.
REQ-042 Reset asserted during MEM of an SW -> dMemWrtEn=0 in the next cycle and state=0.
